// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings and the
// control-FSM state encoding used by the decoder and the control unit.
package alu_pkg;

    // Opcode encodings carried on ALUOp
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MUL  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_SLT  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    // Control FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_HOLD = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath.
// A start pulse loads the operands; the unit then performs one shift-add
// step per cycle for WIDTH cycles. The product wraps modulo 2^WIDTH.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   start_i          : load a_i/b_i and begin iterating
//   a_i, b_i         : multiplicand / multiplier
//   last_o           : the current cycle performs the final iteration
//   product_next_o   : accumulator value after this cycle's step (final product when last_o)
//   product_o        : registered accumulator (holds the product once finished)
module alu_mul_iter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] product_next_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] acc_sum;

    assign acc_sum        = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign last_o         = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign product_next_o = acc_sum;
    assign product_o      = acc_q;

    always_comb begin
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        if (start_i) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            // acc_q keeps the product after the final step
            if (last_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and a registered
// result/flag stage. Single-cycle ops complete with latency 1; MUL uses the
// iterative multiplier and holds in_ready low while it runs.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_valid / in_ready   : operation handshake (a, b, ALUOp)
//   out_valid / out_ready : result handshake
//   Result, Zero, Is_Greater, Carry, Overflow, Illegal : registered result and flags
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH  = 64,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       ALUOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Is_Greater,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    alu_state_e state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             gt_q, gt_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             ill_q, ill_d;
    // a > b of the MUL operands, kept until the product is loaded
    logic             mul_gt_q, mul_gt_d;

    logic             out_free;
    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_last;
    logic [WIDTH-1:0] mul_prod_next;
    logic [WIDTH-1:0] mul_prod;

    // Single-cycle datapath results
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_ill;
    logic [WIDTH:0]     add_w;
    logic [WIDTH:0]     sub_w;
    logic [SHAMT_W-1:0] shamt;

    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (ALUOp == OP_MUL);

    // SUB as a + ~b + 1 so bit WIDTH is directly "not borrow"
    assign add_w = {1'b0, a} + {1'b0, b};
    assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
    assign shamt = b[SHAMT_W-1:0];

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_ill   = 1'b0;
        case (ALUOp)
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_NOR: alu_res = ~(a | b);
            OP_ADD: begin
                alu_res   = add_w[WIDTH-1:0];
                alu_carry = add_w[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = sub_w[WIDTH-1:0];
                alu_carry = sub_w[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_w[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $unsigned($signed(a) >>> shamt);
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_ill = 1'b1;
        endcase
    end

    if (MUL_EN) begin : g_mul
        alu_mul_iter #(
            .WIDTH(WIDTH)
        ) u_mul (
            .clk_i          (clk),
            .reset_i        (reset),
            .start_i        (mul_start),
            .a_i            (a),
            .b_i            (b),
            .last_o         (mul_last),
            .product_next_o (mul_prod_next),
            .product_o      (mul_prod)
        );
    end else begin : g_no_mul
        logic unused_mul_start;
        assign unused_mul_start = mul_start;
        assign mul_last         = 1'b0;
        assign mul_prod_next    = '0;
        assign mul_prod         = '0;
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        gt_d        = gt_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        ill_d       = ill_q;
        mul_gt_d    = mul_gt_q;
        mul_start   = 1'b0;

        // Drain first; a load below overrides it
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (is_mul) begin
                        state_d   = ST_MUL;
                        mul_start = 1'b1;
                        mul_gt_d  = (a > b);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                        zero_d      = (alu_res == '0);
                        gt_d        = (a > b);
                        carry_d     = alu_carry;
                        ovf_d       = alu_ovf;
                        ill_d       = alu_ill;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    if (out_free) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b1;
                        result_d    = mul_prod_next;
                        zero_d      = (mul_prod_next == '0);
                        gt_d        = mul_gt_q;
                        carry_d     = 1'b0;
                        ovf_d       = 1'b0;
                        ill_d       = 1'b0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_free) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = mul_prod;
                    zero_d      = (mul_prod == '0);
                    gt_d        = mul_gt_q;
                    carry_d     = 1'b0;
                    ovf_d       = 1'b0;
                    ill_d       = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b1;
            gt_q        <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ill_q       <= 1'b0;
            mul_gt_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            gt_q        <= gt_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            ill_q       <= ill_d;
            mul_gt_q    <= mul_gt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign Result     = result_q;
    assign Zero       = zero_q;
    assign Is_Greater = gt_q;
    assign Carry      = carry_q;
    assign Overflow   = ovf_q;
    assign Illegal    = ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed timing/boundary tests followed by
// randomized traffic scored against a behavioural model.
module tb_alu_mc;

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_MUL = 4'b0011;
    localparam logic [3:0] C_SUB = 4'b0110, C_SLL = 4'b0111, C_SRL = 4'b1000, C_SRA = 4'b1001;
    localparam logic [3:0] C_SLT = 4'b1010, C_SLTU = 4'b1011, C_NOR = 4'b1100;

    typedef struct packed {
        logic [63:0] res;
        logic        zero;
        logic        gt;
        logic        carry;
        logic        ovf;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [63:0] a, b, Result;
    logic [3:0]  ALUOp;
    logic        Zero, Is_Greater, Carry, Overflow, Illegal;

    // Narrow instance without a multiplier
    logic        n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [7:0]  n_a, n_b, n_result;
    logic [3:0]  n_op;
    logic        n_zero, n_gt, n_carry, n_ovf, n_ill;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    bit   mon_en   = 0;
    bit   rnd_rdy  = 0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(64), .MUL_EN(1'b1)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .ALUOp      (ALUOp),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Zero       (Zero),
        .Is_Greater (Is_Greater),
        .Carry      (Carry),
        .Overflow   (Overflow),
        .Illegal    (Illegal)
    );

    alu_mc #(.WIDTH(8), .MUL_EN(1'b0)) u_dut_nomul (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (n_in_valid),
        .in_ready   (n_in_ready),
        .a          (n_a),
        .b          (n_b),
        .ALUOp      (n_op),
        .out_valid  (n_out_valid),
        .out_ready  (n_out_ready),
        .Result     (n_result),
        .Zero       (n_zero),
        .Is_Greater (n_gt),
        .Carry      (n_carry),
        .Overflow   (n_ovf),
        .Illegal    (n_ill)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural reference for the 64-bit instance
    function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        exp_t        e;
        logic [64:0] u;
        logic [64:0] s;
        logic [63:0] ones;
        logic [63:0] msb;
        int unsigned sh;
        ones = '1;
        msb  = 64'h8000_0000_0000_0000;
        sh   = y[5:0];
        e    = '0;
        case (op)
            C_AND: e.res = x & y;
            C_OR:  e.res = x | y;
            C_NOR: e.res = ~(x | y);
            C_ADD: begin
                u       = {1'b0, x} + {1'b0, y};
                s       = {x[63], x} + {y[63], y};
                e.res   = u[63:0];
                e.carry = u[64];
                e.ovf   = s[64] ^ s[63];
            end
            C_SUB: begin
                s       = {x[63], x} - {y[63], y};
                e.res   = x - y;
                e.carry = (x >= y);
                e.ovf   = s[64] ^ s[63];
            end
            C_SLL: e.res = x << sh;
            C_SRL: e.res = x >> sh;
            C_SRA: e.res = (x >> sh) | (x[63] ? ~(ones >> sh) : 64'd0);
            C_SLT: e.res = {63'd0, ((x ^ msb) < (y ^ msb))};
            C_SLTU: e.res = {63'd0, (x < y)};
            C_MUL: e.res = x * y;
            default: e.ill = 1'b1;
        endcase
        e.zero = (e.res == 64'd0);
        e.gt   = (x > y);
        return e;
    endfunction

    task automatic sample();
        @(negedge clk);
    endtask

    // Directed single issue: the block is expected to be ready
    task automatic issue(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        ALUOp    = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        #1;
        check("issue_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Randomized issue: wait (bounded) for in_ready, log expectation on accept
    task automatic send(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        int waited;
        bit done;
        waited   = 0;
        done     = 0;
        ALUOp    = op;
        a        = x;
        b        = y;
        in_valid = 1'b1;
        while (!done) begin
            if (rnd_rdy) out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(op, x, y));
                done = 1;
            end else if (waited++ > 300) begin
                check("send_timeout", 64'd0, 64'd1);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Scoreboard: every drained result must match the oldest accepted op
    logic [63:0] held_res;
    bit          held = 0;
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !reset) begin
            if (held) begin
                check("hold_valid", {63'd0, out_valid}, 64'd1);
                check("hold_stable", Result, held_res);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rnd_result", Result, e.res);
                    check("rnd_flags", {59'd0, Zero, Is_Greater, Carry, Overflow, Illegal},
                          {59'd0, e.zero, e.gt, e.carry, e.ovf, e.ill});
                end
            end
            held     = out_valid && !out_ready;
            held_res = Result;
        end else begin
            held = 0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   cnt;
        int   vcnt;
        int   bad;
        bit   seen_rdy;
        exp_t e;
        logic [63:0] ma, mb, x, y;
        logic [3:0]  op;

        reset       = 1'b1;
        in_valid    = 1'b0;
        a           = '0;
        b           = '0;
        ALUOp       = '0;
        out_ready   = 1'b0;
        n_in_valid  = 1'b0;
        n_a         = '0;
        n_b         = '0;
        n_op        = '0;
        n_out_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        sample();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_zero", {63'd0, Zero}, 64'd1);
        check("rst_result", Result, 64'd0);
        check("rst_flags", {60'd0, Is_Greater, Carry, Overflow, Illegal}, 64'd0);

        // ADD wrap-around
        out_ready = 1'b1;
        issue(C_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        sample();
        check("add_valid", {63'd0, out_valid}, 64'd1);
        check("add_result", Result, 64'd0);
        check("add_zcov", {61'd0, Zero, Carry, Overflow}, {61'd0, 3'b110});

        // SUB signed overflow
        issue(C_SUB, 64'h8000_0000_0000_0000, 64'd1);
        sample();
        check("sub_result", Result, 64'h7FFF_FFFF_FFFF_FFFF);
        check("sub_ovf_gt", {62'd0, Overflow, Is_Greater}, {62'd0, 2'b11});
        check("sub_carry", {63'd0, Carry}, 64'd1);

        // SRA ignores upper shift bits
        issue(C_SRA, 64'h8000_0000_0000_0000, 64'h43);
        sample();
        check("sra_result", Result, 64'hF000_0000_0000_0000);

        // MUL latency
        issue(C_MUL, 64'd12345, 64'd678);
        cnt      = 0;
        seen_rdy = 0;
        sample();
        while (!out_valid && cnt < 200) begin
            if (in_ready) seen_rdy = 1;
            cnt++;
            sample();
        end
        check("mul_latency", 64'(cnt), 64'd64);
        check("mul_busy_ready", {63'd0, seen_rdy}, 64'd0);
        check("mul_result", Result, 64'd8369910);

        // AND accepted as the product drains, then MUL under back-pressure
        issue(C_AND, 64'hF0F0_F0F0_1234_5678, 64'hFF00_FF00_FFFF_0000);
        sample();
        check("and_result", Result, 64'hF000_F000_1234_0000);
        ma = 64'hDEAD_BEEF_0BAD_F00D;
        mb = 64'h1234_5678_9ABC_DEF1;
        issue(C_MUL, ma, mb);
        out_ready = 1'b0;
        e         = model(C_MUL, ma, mb);
        vcnt      = 0;
        bad       = 0;
        seen_rdy  = 0;
        repeat (100) begin
            sample();
            if (in_ready) seen_rdy = 1;
            if (out_valid) begin
                vcnt++;
                if (Result !== e.res) bad++;
            end
        end
        check("bp_valid_cycles", 64'(vcnt), 64'd36);
        check("bp_product_stable", 64'(bad), 64'd0);
        check("bp_no_ready", {63'd0, seen_rdy}, 64'd0);
        check("bp_gt", {63'd0, Is_Greater}, {63'd0, e.gt});
        out_ready = 1'b1;
        #1;
        check("bp_ready_on_drain", {63'd0, in_ready}, 64'd1);
        sample();
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // Reset during MUL iterations
        issue(C_MUL, 64'hFFFF, 64'hFFFF);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sample();
        check("rmul_valid", {63'd0, out_valid}, 64'd0);
        check("rmul_ready", {63'd0, in_ready}, 64'd1);
        vcnt = 0;
        repeat (80) begin
            sample();
            if (out_valid) vcnt++;
        end
        check("rmul_discarded", 64'(vcnt), 64'd0);
        issue(C_OR, 64'd5, 64'd10);
        sample();
        check("or_result", Result, 64'd15);

        // Reset while in_valid is high: no accept
        reset    = 1'b1;
        in_valid = 1'b1;
        ALUOp    = C_OR;
        a        = 64'd1;
        b        = 64'd2;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        sample();
        check("rst_inv_no_accept", {63'd0, out_valid}, 64'd0);

        // Illegal opcode
        issue(4'b1111, 64'd123, 64'd45);
        sample();
        check("ill_result", Result, 64'd0);
        check("ill_flags", {59'd0, Zero, Is_Greater, Carry, Overflow, Illegal},
              {59'd0, 5'b11001});

        // Narrow instance: MUL is illegal, single-cycle latency
        n_op       = C_MUL;
        n_a        = 8'd7;
        n_b        = 8'd9;
        n_in_valid = 1'b1;
        #1;
        check("nm_ready", {63'd0, n_in_ready}, 64'd1);
        @(posedge clk);
        #1;
        n_op = C_ADD;
        n_a  = 8'h7F;
        n_b  = 8'h01;
        sample();
        check("nm_mul_valid", {63'd0, n_out_valid}, 64'd1);
        check("nm_mul_illegal", {63'd0, n_ill}, 64'd1);
        check("nm_mul_result", {56'd0, n_result}, 64'd0);
        @(posedge clk);
        #1;
        n_in_valid = 1'b0;
        sample();
        check("nm_add_result", {56'd0, n_result}, 64'h80);
        check("nm_add_flags", {61'd0, n_carry, n_ovf, n_ill}, {61'd0, 3'b010});

        // Randomized traffic
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        mon_en  = 1;
        rnd_rdy = 1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 5))
                0:       x = 64'd0;
                1:       x = 64'hFFFF_FFFF_FFFF_FFFF;
                2:       x = 64'h8000_0000_0000_0000;
                default: x = {$urandom, $urandom};
            endcase
            case ($urandom_range(0, 5))
                0:       y = 64'd0;
                1:       y = x;
                2:       y = 64'h7FFF_FFFF_FFFF_FFFF;
                default: y = {$urandom, $urandom};
            endcase
            send(op, x, y);
        end
        rnd_rdy   = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        mon_en = 0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
